// File: rtl/tsc_key_recover.sv
// -----------------------------------------------------------------------------
// tsc_key_recover
//
// Receive-side decoder for the TSC key-leak channel.  A trigger (Tj_Trig)
// re-seeds an 8-bit whitening LFSR and opens a capture window.  Each accepted
// leak sample is de-whitened with lfsr[0] and added to the vote counter of the
// key bit it carries (MSB first).  After REPS complete frames of KEY_W bits,
// every key bit is decided by strict majority and presented on key_out.
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-high reset
//   Tj_Trig    in   1      frame sync; starts or restarts a capture
//   leak_valid in   1      leak_bit carries a sample this cycle
//   leak_bit   in   1      whitened leak sample
//   key_out    out  KEY_W  recovered key (holds until next trigger/reset)
//   key_valid  out  1      key_out holds a completed recovery
//   busy       out  1      capture in progress
//   err        out  1      one-cycle timeout-abort pulse
//
// Optional feature macro: TSC_TIMEOUT_EN
//   Defined   : an idle-gap counter aborts a capture after TIMEOUT cycles
//               without samples and pulses err.  Adds parameter TIMEOUT.
//   Undefined : no gap counter, err is held at 0, capture waits forever.
// -----------------------------------------------------------------------------
module tsc_key_recover #(
  parameter int         KEY_W     = 128,
  parameter int         REPS      = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
`ifdef TSC_TIMEOUT_EN
  ,
  parameter int         TIMEOUT   = 256
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Tj_Trig,
  input  logic             leak_valid,
  input  logic             leak_bit,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err
);

  // Vote counters only ever count up to REPS, so this width never overflows.
  localparam int CW = $clog2(REPS + 1);
  localparam int IW = (KEY_W > 1) ? $clog2(KEY_W) : 1;
  localparam int RW = (REPS > 1) ? $clog2(REPS) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(KEY_W - 1);
  localparam logic [RW-1:0] REP_LAST = RW'(REPS - 1);
  localparam logic [CW-1:0] VOTE_THR = CW'(REPS / 2);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1: shift left, feedback into bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    lfsr_next = {cur[6:0], cur[7] ^ cur[5] ^ cur[4] ^ cur[3]};
  endfunction

  state_t           state_r;
  state_t           state_next_s;
  logic [7:0]       lfsr_r;
  logic [IW-1:0]    idx_r;
  logic [RW-1:0]    rep_r;
  logic [CW-1:0]    vote_r [KEY_W];
  logic [KEY_W-1:0] maj_s;
  logic [KEY_W-1:0] key_out_r;
  logic             key_valid_r;
  logic             busy_r;
  logic             err_r;

  logic             start_s;
  logic             accept_s;
  logic             last_s;
  logic             d_s;
  logic [IW-1:0]    vidx_s;
  logic             timeout_s;

  // A trigger is honoured in IDLE and CAPTURE only; DONE always completes.
  // A sample coinciding with a trigger is discarded.
  assign start_s  = Tj_Trig & ((state_r == ST_IDLE) | (state_r == ST_CAPTURE));
  assign accept_s = (state_r == ST_CAPTURE) & ~Tj_Trig & leak_valid;
  assign last_s   = accept_s & (idx_r == IDX_LAST) & (rep_r == REP_LAST);
  assign d_s      = leak_bit ^ lfsr_r[0];
  // Bits arrive MSB first, so sample idx lands on key bit KEY_W-1-idx.
  assign vidx_s   = IDX_LAST - idx_r;

`ifdef TSC_TIMEOUT_EN
  localparam int GW = $clog2(TIMEOUT + 1);
  logic [GW-1:0] gap_r;

  // Idle-gap counter: cleared by activity, counts empty CAPTURE cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_r <= '0;
    end else if (start_s || accept_s) begin
      gap_r <= '0;
    end else if ((state_r == ST_CAPTURE) && !leak_valid) begin
      gap_r <= gap_r + GW'(1);
    end else begin
      gap_r <= gap_r;
    end
  end

  // Abort on the empty cycle that brings the gap count to TIMEOUT.
  assign timeout_s = (state_r == ST_CAPTURE) & ~Tj_Trig & ~leak_valid &
                     (gap_r == GW'(TIMEOUT - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (Tj_Trig) begin
          state_next_s = ST_CAPTURE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_CAPTURE: begin
        if (Tj_Trig) begin
          state_next_s = ST_CAPTURE;
        end else if (last_s) begin
          state_next_s = ST_DONE;
        end else if (timeout_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_CAPTURE;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Whitening LFSR and frame position (bit index, repetition index).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_r <= LFSR_SEED;
      idx_r  <= '0;
      rep_r  <= '0;
    end else if (start_s) begin
      lfsr_r <= LFSR_SEED;
      idx_r  <= '0;
      rep_r  <= '0;
    end else if (accept_s) begin
      lfsr_r <= lfsr_next(lfsr_r);
      if (idx_r == IDX_LAST) begin
        idx_r <= '0;
        rep_r <= (rep_r == REP_LAST) ? '0 : rep_r + RW'(1);
      end else begin
        idx_r <= idx_r + IW'(1);
        rep_r <= rep_r;
      end
    end else begin
      lfsr_r <= lfsr_r;
      idx_r  <= idx_r;
      rep_r  <= rep_r;
    end
  end

  // Per-bit vote counters: count de-whitened ones for each key bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < KEY_W; i++) begin
        vote_r[i] <= '0;
      end
    end else if (start_s) begin
      for (int i = 0; i < KEY_W; i++) begin
        vote_r[i] <= '0;
      end
    end else if (accept_s && d_s) begin
      vote_r[vidx_s] <= vote_r[vidx_s] + CW'(1);
    end
  end

  // Strict majority per bit: more than REPS/2 votes for one.
  always_comb begin
    maj_s = '0;
    for (int i = 0; i < KEY_W; i++) begin
      maj_s[i] = (vote_r[i] > VOTE_THR);
    end
  end

  // Registered outputs: key, key_valid and busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_out_r   <= '0;
      key_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else if (start_s) begin
      key_out_r   <= key_out_r;
      key_valid_r <= 1'b0;
      busy_r      <= 1'b1;
    end else if (state_r == ST_DONE) begin
      key_out_r   <= maj_s;
      key_valid_r <= 1'b1;
      busy_r      <= 1'b0;
    end else if (timeout_s) begin
      key_out_r   <= key_out_r;
      key_valid_r <= key_valid_r;
      busy_r      <= 1'b0;
    end else begin
      key_out_r   <= key_out_r;
      key_valid_r <= key_valid_r;
      busy_r      <= busy_r;
    end
  end

  // Timeout-abort pulse; constant zero when the gap counter is absent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= timeout_s;
    end
  end

  assign key_out   = key_out_r;
  assign key_valid = key_valid_r;
  assign busy      = busy_r;
  assign err       = err_r;

endmodule

// File: tb/tb_tsc_key_recover.sv
// -----------------------------------------------------------------------------
// tb_tsc_key_recover
//
// Directed bench for tsc_key_recover.  A local whitening model produces the
// leak stream; the expected key of each full capture is pushed to a scoreboard
// queue when the stream starts and popped when key_valid rises.
// -----------------------------------------------------------------------------
module tb_tsc_key_recover;

  localparam int KW = 128;

  logic          clk;
  logic          rst;
  logic          Tj_Trig;
  logic          leak_valid;
  logic          leak_bit;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          busy;
  logic          err;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int trig_cyc = 0;

  logic [KW-1:0] sb [$];

  tsc_key_recover dut (
    .clk        (clk),
    .rst        (rst),
    .Tj_Trig    (Tj_Trig),
    .leak_valid (leak_valid),
    .leak_bit   (leak_bit),
    .key_out    (key_out),
    .key_valid  (key_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] wstep(input logic [7:0] l);
    logic fb;
    fb = l[7] ^ l[5] ^ l[4] ^ l[3];
    return {l[6:0], fb};
  endfunction

  // Called at a negedge; raises Tj_Trig for one edge, optionally with a
  // sample that must be discarded.
  task automatic trigger(input bit with_sample);
    Tj_Trig    = 1'b1;
    leak_valid = with_sample;
    leak_bit   = 1'b1;
    @(negedge clk);
    Tj_Trig    = 1'b0;
    leak_valid = 1'b0;
    trig_cyc   = cyc;
  endtask

  // Streams nsamp whitened samples of key (MSB first, frames repeated).
  task automatic drive_stream(input logic [KW-1:0] key, input int flip_bit,
                              input logic [2:0] flip_reps, input bit gapped,
                              input int nsamp);
    logic [7:0] l;
    logic       b;
    int         rep;
    int         bitpos;
    l = 8'hA5;
    for (int s = 0; s < nsamp; s++) begin
      rep    = s / KW;
      bitpos = KW - 1 - (s % KW);
      b      = key[bitpos];
      if (flip_reps[rep] && (bitpos == flip_bit)) b = ~b;
      if (gapped) begin
        leak_valid = 1'b0;
        @(negedge clk);
      end
      leak_valid = 1'b1;
      leak_bit   = b ^ l[0];
      l          = wstep(l);
      @(negedge clk);
    end
    leak_valid = 1'b0;
    leak_bit   = 1'b0;
  endtask

  // Waits (bounded) for key_valid, then checks against the scoreboard.
  task automatic wait_key(input string tag, input int exp_lat);
    int            n;
    logic [KW-1:0] e;
    n = 0;
    while (!key_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_kv"}, KW'(key_valid), KW'(1'b1));
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    check({tag, "_key"}, key_out, e);
    check({tag, "_busy"}, KW'(busy), KW'(1'b0));
    check({tag, "_lat"}, KW'(cyc - trig_cyc), KW'(exp_lat));
  endtask

  localparam logic [KW-1:0] KEY_A   = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA;
  localparam logic [KW-1:0] KEY_A5  = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAA8A;
  localparam logic [KW-1:0] KEY_G   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [KW-1:0] KEY_P   = 128'hDEADBEEF_00112233_44556677_8899AABB;
  localparam logic [KW-1:0] KEY_R   = 128'hFEDCBA98_76543210_0F1E2D3C_4B5A6978;

  initial begin
    int err_cnt;
    int err_cyc;
    int last_cyc;

    rst        = 1'b1;
    Tj_Trig    = 1'b0;
    leak_valid = 1'b0;
    leak_bit   = 1'b0;

    // Reset state
    #12;
    check("rst_key", key_out, '0);
    check("rst_kv", KW'(key_valid), KW'(1'b0));
    check("rst_busy", KW'(busy), KW'(1'b0));
    check("rst_err", KW'(err), KW'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Clean recovery
    sb.push_back(KEY_A);
    trigger(1'b0);
    check("clean_busy", KW'(busy), KW'(1'b1));
    drive_stream(KEY_A, 0, 3'b000, 1'b0, 3 * KW);
    check("clean_kv_pre", KW'(key_valid), KW'(1'b0));
    wait_key("clean", 385);

    // Single-rep noise on bit 5
    @(negedge clk);
    check("hold_kv", KW'(key_valid), KW'(1'b1));
    sb.push_back(KEY_A);
    trigger(1'b0);
    check("single_kv_clr", KW'(key_valid), KW'(1'b0));
    drive_stream(KEY_A, 5, 3'b010, 1'b0, 3 * KW);
    wait_key("single", 385);

    // Double-rep noise on bit 5 outvotes the true value
    @(negedge clk);
    sb.push_back(KEY_A5);
    trigger(1'b0);
    drive_stream(KEY_A, 5, 3'b101, 1'b0, 3 * KW);
    wait_key("double", 385);

    // Gapped stream
    @(negedge clk);
    sb.push_back(KEY_G);
    trigger(1'b0);
    drive_stream(KEY_G, 0, 3'b000, 1'b1, 3 * KW);
    wait_key("gapped", 769);

    // Retrigger after 200 samples; sample in the retrigger cycle is dropped
    @(negedge clk);
    trigger(1'b0);
    drive_stream(KEY_P, 0, 3'b000, 1'b0, 200);
    check("retrig_busy", KW'(busy), KW'(1'b1));
    sb.push_back(KEY_R);
    trigger(1'b1);
    drive_stream(KEY_R, 0, 3'b000, 1'b0, 3 * KW);
    wait_key("retrig", 385);

    // Asynchronous reset mid-capture
    @(negedge clk);
    trigger(1'b0);
    drive_stream(KEY_G, 0, 3'b000, 1'b0, 100);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_key", key_out, '0);
    check("mrst_kv", KW'(key_valid), KW'(1'b0));
    check("mrst_busy", KW'(busy), KW'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    drive_stream(KEY_G, 0, 3'b000, 1'b0, 300);
    check("mrst_kv_after", KW'(key_valid), KW'(1'b0));
    check("mrst_busy_after", KW'(busy), KW'(1'b0));

    // Stalled stream after 50 samples
    trigger(1'b0);
    drive_stream(KEY_G, 0, 3'b000, 1'b0, 50);
    last_cyc = cyc;
    err_cnt  = 0;
    err_cyc  = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
`ifdef TSC_TIMEOUT_EN
    check("to_err_cnt", KW'(err_cnt), KW'(1));
    check("to_err_lat", KW'(err_cyc - last_cyc), KW'(256));
    check("to_busy", KW'(busy), KW'(1'b0));
`else
    check("to_err_cnt", KW'(err_cnt), KW'(0));
    check("to_busy", KW'(busy), KW'(1'b1));
`endif
    check("to_kv", KW'(key_valid), KW'(1'b0));
    check("sb_empty", KW'(sb.size()), KW'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
